stopwatch_core: RTL

STOPWATCH_CORE -- requirements
Module: stopwatch_core

---
 rtl/stopwatch_pkg.sv | 20 ++
 rtl/bcd_digit_cnt.sv | 16 +
 rtl/stopwatch_core.sv | 92 +++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: FSM states, digit limits and bcd_out field offsets shared with the display stage.
// LAP exists only when STOPWATCH_LAP_EN is defined.
package stopwatch_pkg;
`ifdef STOPWATCH_LAP_EN
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
`endif
    localparam int DIGIT_MAX9 = 9;
    localparam int DIGIT_MAX5 = 5;
    localparam int TM1_LSB    = 0;
    localparam int TM10_LSB   = 4;
    localparam int SEC1_LSB   = 8;
    localparam int SEC10_LSB  = 12;
    localparam int MIN1_LSB   = 16;
    localparam int MIN10_LSB  = 20;
    function automatic int digit_max(input int i);
        return (i == 3 || i == 5) ? DIGIT_MAX5 : DIGIT_MAX9;
    endfunction
endpackage

// File: rtl/bcd_digit_cnt.sv
// bcd_digit_cnt: one BCD digit 0..MAX; carry is combinational so a chain ripples in one cycle.
module bcd_digit_cnt #(
    parameter int MAX = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] digit,
    output logic       carry
);
    assign carry = inc && digit == 4'(MAX);
    always_ff @(posedge clk or posedge rst)
        if (rst) digit <= '0;
        else     digit <= clr ? 4'd0 : carry ? 4'd0 : inc ? digit + 4'd1 : digit;
endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: mm:ss.cc stopwatch with start/stop, clear and sticky wrap flag.
// Define STOPWATCH_LAP_EN to add the LAP state that freezes bcd_out while counting continues.
module stopwatch_core #(
    parameter int TICK_DIV = 10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [23:0] bcd_out,
    output logic        running,
    output logic        lap_active,
    output logic        ovf
);
    import stopwatch_pkg::*;
    state_t      state, nxt;
    logic        ss_q, clr_q, ss_e, clr_e, tick, hold;
    logic [15:0] presc;
    logic [5:0]  inc, carry;
    logic [23:0] cnt;
`ifdef STOPWATCH_LAP_EN
    logic lap_q, lap_e;
    always_ff @(posedge clk or posedge rst)
        if (rst) lap_q <= 1'b0;
        else     lap_q <= lap;
    assign lap_e = lap && !lap_q;
    assign hold  = state == LAP && nxt == LAP;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign hold       = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) {ss_q, clr_q} <= '0;
        else     {ss_q, clr_q} <= {start_stop, clear};
    assign ss_e  = start_stop && !ss_q;
    assign clr_e = clear && !clr_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= nxt;
    always_comb begin
        nxt = state;
        if (clr_e) nxt = IDLE;
        else
            case (state)
                IDLE:    nxt = ss_e ? RUN : IDLE;
`ifdef STOPWATCH_LAP_EN
                RUN:     nxt = ss_e ? PAUSE : lap_e ? LAP : RUN;
                LAP:     nxt = ss_e ? PAUSE : lap_e ? RUN : LAP;
`else
                RUN:     nxt = ss_e ? PAUSE : RUN;
`endif
                PAUSE:   nxt = ss_e ? RUN : PAUSE;
                default: nxt = IDLE;
            endcase
    end
    always_comb begin
`ifdef STOPWATCH_LAP_EN
        running    = state == RUN || state == LAP;
        lap_active = state == LAP;
`else
        running    = state == RUN;
        lap_active = 1'b0;
`endif
    end
    assign tick = running && presc == 16'(TICK_DIV - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst)                                       presc <= '0;
        else if (clr_e || (state == IDLE && ss_e) || tick) presc <= '0;
        else if (running)                              presc <= presc + 16'd1;
    assign inc = {carry[4:0], tick};
    for (genvar g = 0; g < 6; g++) begin : g_dig
        bcd_digit_cnt #(.MAX(digit_max(g))) u_dig (
            .clk  (clk),
            .rst  (rst),
            .inc  (inc[g]),
            .clr  (clr_e),
            .digit(cnt[4*g +: 4]),
            .carry(carry[g])
        );
    end
    always_ff @(posedge clk or posedge rst)
        if (rst)           ovf <= 1'b0;
        else if (clr_e)    ovf <= 1'b0;
        else if (carry[5]) ovf <= 1'b1;
    // In LAP the register itself is the capture: it simply stops loading
    always_ff @(posedge clk or posedge rst)
        if (rst)        bcd_out <= '0;
        else if (clr_e) bcd_out <= '0;
        else if (!hold) bcd_out <= cnt;
endmodule
